// File: rtl/avalon_pio_port_pkg.sv
// Shared constants for the Avalon-MM parallel I/O port.
// Register map, edge-type encodings and the edge selection helper.
package pio_pkg;

   localparam int PIO_MAX_WIDTH = 32;

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
   localparam logic [2:0] ADDR_OUTTGL  = 3'd6;
   localparam logic [2:0] ADDR_RSVD    = 3'd7;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   function automatic logic [PIO_MAX_WIDTH-1:0] edge_mask(
      input int                       etype,
      input logic [PIO_MAX_WIDTH-1:0] cur,
      input logic [PIO_MAX_WIDTH-1:0] prev
   );
      logic [PIO_MAX_WIDTH-1:0] rise;
      logic [PIO_MAX_WIDTH-1:0] fall;
      rise = cur & ~prev;
      fall = ~cur & prev;
      if (etype == EDGE_RISING)
         return rise;
      else if (etype == EDGE_FALLING)
         return fall;
      else
         return rise | fall;
   endfunction

endpackage

// File: rtl/avalon_pio_port_if.sv
// Avalon-MM slave bus bundle for the parallel I/O port.
// The CPU side uses master, the peripheral uses slave.
interface avalon_pio_port_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/avalon_pio_port_edge_detect.sv
// Input synchroniser, delay flop and edge pulse generator.
// A priming counter masks edges until the pipeline holds real pin data.
module pio_edge_detect
   import pio_pkg::*;
#(
   parameter int WIDTH       = 10,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = EDGE_RISING
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] sync_out,
   output logic [WIDTH-1:0] edge_pulse
);

   localparam logic [2:0] PRIME_CYCLES = 3'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
   logic [WIDTH-1:0]                  dly_q;
   logic [2:0]                        prime_cnt;
   logic                              primed;
   logic [WIDTH-1:0]                  hit;

   assign primed   = (prime_cnt == PRIME_CYCLES);
   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '0;
         dly_q     <= '0;
         prime_cnt <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
         dly_q  <= sync_q[SYNC_STAGES-1];
         if (!primed)
            prime_cnt <= prime_cnt + 3'd1;
      end
   end

   always_comb begin
      hit = WIDTH'(edge_mask(EDGE_TYPE,
                             PIO_MAX_WIDTH'(sync_out),
                             PIO_MAX_WIDTH'(dly_q)));
      edge_pulse = primed ? hit : '0;
   end

endmodule

// File: rtl/avalon_pio_port.sv
// Avalon-MM parallel I/O port: data/direction registers, atomic
// set/clear/toggle, edge capture with maskable level interrupt.
module avalon_pio_port
   import pio_pkg::*;
#(
   parameter int               WIDTH       = 10,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter logic [WIDTH-1:0] DIR_RESET   = '1,
   parameter int               EDGE_TYPE   = EDGE_RISING,
   parameter int               SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   avalon_pio_port_if.slave   bus,
   input  logic [WIDTH-1:0]   in_port,
   output logic [WIDTH-1:0]   out_port,
   output logic [WIDTH-1:0]   oe,
   output logic               irq
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] mask_q;
   logic [WIDTH-1:0] ecap_q;
   logic             irq_q;

   logic [WIDTH-1:0] data_nxt;
   logic [WIDTH-1:0] dir_nxt;
   logic [WIDTH-1:0] mask_nxt;
   logic [WIDTH-1:0] ecap_clr;
   logic [WIDTH-1:0] ecap_set;
   logic [WIDTH-1:0] rd_val;

   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] edge_pulse;
   logic             wr;
   logic [WIDTH-1:0] wd;

   pio_edge_detect #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_edge (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_port    (in_port),
      .sync_out   (sync_in),
      .edge_pulse (edge_pulse)
   );

   assign wr = bus.chipselect & ~bus.write_n;
   assign wd = bus.writedata[WIDTH-1:0];

   // Only pins configured as inputs may record an edge.
   assign ecap_set = edge_pulse & ~dir_q;

   always_comb begin
      data_nxt = data_q;
      dir_nxt  = dir_q;
      mask_nxt = mask_q;
      ecap_clr = '0;
      if (wr) begin
         unique case (bus.address)
            ADDR_DATA:    data_nxt = wd;
            ADDR_DIR:     dir_nxt  = wd;
            ADDR_IRQMASK: mask_nxt = wd;
            ADDR_EDGECAP: ecap_clr = wd;
            ADDR_OUTSET:  data_nxt = data_q | wd;
            ADDR_OUTCLR:  data_nxt = data_q & ~wd;
            ADDR_OUTTGL:  data_nxt = data_q ^ wd;
            default:      ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= RESET_VALUE;
         dir_q  <= DIR_RESET;
         mask_q <= '0;
         ecap_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         data_q <= data_nxt;
         dir_q  <= dir_nxt;
         mask_q <= mask_nxt;
         // A fresh edge outranks a clear on the same bit.
         ecap_q <= (ecap_q & ~ecap_clr) | ecap_set;
         irq_q  <= |(ecap_q & mask_q);
      end
   end

   always_comb begin
      rd_val = '0;
      unique case (bus.address)
         ADDR_DATA:    rd_val = (data_q & dir_q) | (sync_in & ~dir_q);
         ADDR_DIR:     rd_val = dir_q;
         ADDR_IRQMASK: rd_val = mask_q;
         ADDR_EDGECAP: rd_val = ecap_q;
         default:      rd_val = '0;
      endcase
   end

   assign bus.readdata = PIO_MAX_WIDTH'(rd_val);
   assign out_port     = data_q;
   assign oe           = dir_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_avalon_pio_port.sv
// Self-checking bench for avalon_pio_port: write table with a
// scoreboard queue, plus hand sequences for capture and priming.
module tb_avalon_pio_port;
   import pio_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   avalon_pio_port_if bus ();
   avalon_pio_port_if bus_p ();

   logic [9:0] in_port = '0;
   logic [9:0] out_port;
   logic [9:0] oe;
   logic       irq;
   logic [9:0] in_p = '1;
   logic [9:0] out_p;
   logic [9:0] oe_p;
   logic       irq_p;

   avalon_pio_port #(
      .WIDTH       (10),
      .RESET_VALUE (10'h155),
      .DIR_RESET   (10'h3FF),
      .EDGE_TYPE   (EDGE_RISING),
      .SYNC_STAGES (2)
   ) u_dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus),
      .in_port  (in_port),
      .out_port (out_port),
      .oe       (oe),
      .irq      (irq)
   );

   avalon_pio_port #(
      .WIDTH       (10),
      .RESET_VALUE (10'h000),
      .DIR_RESET   (10'h000),
      .EDGE_TYPE   (EDGE_RISING),
      .SYNC_STAGES (2)
   ) u_prm (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus_p),
      .in_port  (in_p),
      .out_port (out_p),
      .oe       (oe_p),
      .irq      (irq_p)
   );

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wd;
      logic [9:0]  exp;
   } vec_t;

   vec_t       vecs [6];
   logic [9:0] sb_q [$];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus.chipselect = 1'b0;
      bus.write_n    = 1'b1;
   endtask

   task automatic chk_rd(input string nm, input logic [2:0] a,
                         input logic [31:0] exp);
      bus.address    = a;
      bus.chipselect = 1'b1;
      bus.write_n    = 1'b1;
      #1;
      check(nm, bus.readdata, exp);
      bus.chipselect = 1'b0;
   endtask

   logic [9:0] prev;
   logic [9:0] e;

   initial begin
      vecs[0] = '{ADDR_DATA,   32'h0000_00F0, 10'h0F0};
      vecs[1] = '{ADDR_OUTSET, 32'h0000_0003, 10'h0F3};
      vecs[2] = '{ADDR_OUTCLR, 32'h0000_0010, 10'h0E3};
      vecs[3] = '{ADDR_OUTTGL, 32'h0000_0300, 10'h3E3};
      vecs[4] = '{ADDR_RSVD,   32'hFFFF_FFFF, 10'h3E3};
      vecs[5] = '{ADDR_DATA,   32'hFFFF_FCAA, 10'h0AA};

      bus.address      = '0;
      bus.chipselect   = 1'b0;
      bus.write_n      = 1'b1;
      bus.writedata    = '0;
      bus_p.address    = ADDR_EDGECAP;
      bus_p.chipselect = 1'b1;
      bus_p.write_n    = 1'b1;
      bus_p.writedata  = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_in_reset", 32'(out_port), 32'h155);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_out", 32'(out_port), 32'h155);
      check("rst_oe", 32'(oe), 32'h3FF);
      check("rst_irq", 32'(irq), 32'h0);
      chk_rd("rst_ecap", ADDR_EDGECAP, 32'h0);

      // Pins held high through reset must not look like an edge.
      repeat (8) @(posedge clk);
      #1;
      check("prime_ecap", bus_p.readdata, 32'h0);
      check("prime_irq", 32'(irq_p), 32'h0);

      prev = 10'h155;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.address    = vecs[i].addr;
         bus.writedata  = vecs[i].wd;
         bus.chipselect = 1'b1;
         bus.write_n    = 1'b0;
         check($sformatf("hold_%0d", i), 32'(out_port), 32'(prev));
         sb_q.push_back(vecs[i].exp);
         @(posedge clk);
         #1;
         bus.chipselect = 1'b0;
         bus.write_n    = 1'b1;
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty_%0d: queue size 0 required 1", i);
         end else begin
            e = sb_q.pop_front();
            check($sformatf("wr_%0d", i), 32'(out_port), 32'(e));
            prev = e;
         end
      end

      // Outputs: pin activity is invisible and never captured.
      @(negedge clk);
      in_port = 10'h35A;
      repeat (5) @(posedge clk);
      #1;
      chk_rd("out_ecap", ADDR_EDGECAP, 32'h0);
      chk_rd("out_data", ADDR_DATA, 32'h0AA);
      chk_rd("rd_set", ADDR_OUTSET, 32'h0);
      chk_rd("rd_clr", ADDR_OUTCLR, 32'h0);
      chk_rd("rd_tgl", ADDR_OUTTGL, 32'h0);
      chk_rd("rd_rsvd", ADDR_RSVD, 32'h0);
      bus_write(ADDR_DIR, 32'hFFFF_FFFF);
      chk_rd("rd_dir_upper", ADDR_DIR, 32'h3FF);

      @(negedge clk);
      in_port = 10'h008;
      repeat (5) @(posedge clk);
      bus_write(ADDR_DIR, 32'h0);
      check("oe_zero", 32'(oe), 32'h0);
      bus_write(ADDR_IRQMASK, 32'h1);
      repeat (4) @(posedge clk);
      #1;
      chk_rd("dirchg_ecap", ADDR_EDGECAP, 32'h0);

      @(negedge clk);
      in_port[0] = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk_rd("cap_e2", ADDR_EDGECAP, 32'h0);
      @(posedge clk);
      #1;
      chk_rd("cap_e3", ADDR_EDGECAP, 32'h1);
      check("irq_e3", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      check("irq_e4", 32'(irq), 32'h1);
      chk_rd("in_data", ADDR_DATA, 32'h009);

      bus_write(ADDR_EDGECAP, 32'h1);
      chk_rd("w1c_ecap", ADDR_EDGECAP, 32'h0);
      check("w1c_irq_hold", 32'(irq), 32'h1);
      @(posedge clk);
      #1;
      check("w1c_irq_clr", 32'(irq), 32'h0);

      @(negedge clk);
      in_port[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk_rd("cap_b1", ADDR_EDGECAP, 32'h2);

      // Bit 2's edge lands on the same edge as the clear of bits 1-2.
      @(negedge clk);
      in_port[2] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      bus_write(ADDR_EDGECAP, 32'h6);
      chk_rd("set_wins", ADDR_EDGECAP, 32'h4);
      @(posedge clk);
      #1;
      check("masked_irq", 32'(irq), 32'h0);
      bus_write(ADDR_EDGECAP, 32'h4);
      chk_rd("clr_b2", ADDR_EDGECAP, 32'h0);

      @(negedge clk);
      in_port[0] = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_rd("fall_ign", ADDR_EDGECAP, 32'h0);
      chk_rd("in_data2", ADDR_DATA, 32'h00E);

      bus_write(ADDR_DATA, 32'h3FF);
      check("pre_rst_out", 32'(out_port), 32'h3FF);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_out", 32'(out_port), 32'h155);
      check("mid_rst_oe", 32'(oe), 32'h3FF);
      check("mid_rst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
